// File: rtl/pixel_fetch_cache.sv
// pixel_fetch_cache -- one-bit-per-pixel fetch cache for a 640x480 frame
// stored as 80 bytes per row in an external image memory.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high
//   flush      single-cycle pulse, invalidates every cached line
//   x, y       requested pixel column / row
//   pixel      requested pixel value, meaningful only while ready=1
//   ready      combinational; pixel is valid for the current x,y
//   rdaddress  registered byte address to image memory
//   rdata      byte returned by image memory RD_LATENCY edges later
//
// Parameter RD_LATENCY (1..3): clock edges from rdaddress to valid rdata.
//
// Build option: define PIXEL_FETCH_PREFETCH_EN for a two-line cache with
// LRU replacement and next-byte prefetch after every demand fill. Without
// it the cache holds a single line that every fill replaces.
module pixel_fetch_cache #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        pixel,
  output logic        ready,
  output logic [15:0] rdaddress,
  input  logic [7:0]  rdata
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  WAIT      = 2'd1;
  localparam logic [1:0]  FILL      = 2'd2;
  localparam logic [1:0]  WAIT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [15:0] LAST_ADDR = 16'd38399;

  logic [1:0]  state;
  logic [1:0]  wait_cnt;
  logic [15:0] y_ext;
  logic [15:0] req_addr;
  logic        in_frame;
  logic        line_hit;
  logic [7:0]  hit_data;
  logic        issue;

  // y*80 as y*64 + y*16
  assign y_ext    = {6'b0, y};
  assign req_addr = (y_ext << 6) + (y_ext << 4) + {9'b0, x[9:3]};
  assign in_frame = (x < 10'd640) && (y < 10'd480);

  assign ready = (state == IDLE) && (!in_frame || line_hit);
  assign pixel = ready && in_frame && hit_data[x[2:0]];
  assign issue = (state == IDLE) && in_frame && !line_hit;

`ifdef PIXEL_FETCH_PREFETCH_EN
  logic [7:0]  line_data [2];
  logic [15:0] line_tag  [2];
  logic [1:0]  line_valid;
  logic [1:0]  way_hit;
  logic        lru;
  logic        fill_way;
  logic        fill_is_pf;
  logic        pf_pending;
  logic [15:0] pf_addr;
  logic        pf_cached;
  logic        pf_issue;

  assign way_hit[0] = line_valid[0] && (line_tag[0] == req_addr);
  assign way_hit[1] = line_valid[1] && (line_tag[1] == req_addr);
  assign line_hit   = |way_hit;
  assign hit_data   = way_hit[0] ? line_data[0] : line_data[1];
  assign pf_cached  = (line_valid[0] && (line_tag[0] == pf_addr)) ||
                      (line_valid[1] && (line_tag[1] == pf_addr));
  assign pf_issue   = (state == IDLE) && in_frame && line_hit &&
                      pf_pending && !pf_cached;
`else
  logic [7:0]  line_data;
  logic [15:0] line_tag;
  logic        line_valid;

  assign line_hit = line_valid && (line_tag == req_addr);
  assign hit_data = line_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rdaddress  <= '0;
      line_valid <= '0;
`ifdef PIXEL_FETCH_PREFETCH_EN
      for (int unsigned i = 0; i < 2; i++) begin
        line_data[i] <= '0;
        line_tag[i]  <= '0;
      end
      lru        <= 1'b0;
      fill_way   <= 1'b0;
      fill_is_pf <= 1'b0;
      pf_pending <= 1'b0;
      pf_addr    <= '0;
`else
      line_data  <= '0;
      line_tag   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef PIXEL_FETCH_PREFETCH_EN
          if (issue || pf_issue) begin
            rdaddress <= issue ? req_addr : pf_addr;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
          if (issue) begin
            fill_way   <= lru;
            fill_is_pf <= 1'b0;
            pf_pending <= 1'b0;
          end else if (in_frame && line_hit) begin
            // A hit makes the other way LRU; a prefetch issued in this
            // same cycle therefore never evicts the line just used.
            lru        <= way_hit[0];
            fill_way   <= way_hit[0];
            fill_is_pf <= 1'b1;
            pf_pending <= 1'b0;
          end
`else
          if (issue) begin
            rdaddress <= req_addr;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
`endif
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= FILL;
          else wait_cnt <= wait_cnt + 2'd1;
        end
        FILL: begin
`ifdef PIXEL_FETCH_PREFETCH_EN
          line_data[fill_way]  <= rdata;
          line_tag[fill_way]   <= rdaddress;
          line_valid[fill_way] <= 1'b1;
          lru                  <= ~fill_way;
          if (!fill_is_pf && (rdaddress < LAST_ADDR)) begin
            pf_pending <= 1'b1;
            pf_addr    <= rdaddress + 16'd1;
          end
`else
          line_data  <= rdata;
          line_tag   <= rdaddress;
          line_valid <= 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed after the FILL write so a coincident flush leaves the line invalid.
      if (flush) line_valid <= '0;
    end
  end

endmodule

// File: tb/tb_pixel_fetch_cache.sv
module tb_pixel_fetch_cache;

  localparam int unsigned LAT    = 1;
  localparam int          BUDGET = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        pixel;
  logic        ready;
  logic [15:0] rdaddress;
  logic [7:0]  rdata;

  logic [7:0]  mem [38400];
  logic [15:0] pipe [LAT];

  pixel_fetch_cache #(.RD_LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .x(x),
    .y(y),
    .pixel(pixel),
    .ready(ready),
    .rdaddress(rdaddress),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Image memory: rdata reflects the address seen LAT rising edges earlier.
  always @(posedge clk) begin
    pipe[0] <= rdaddress;
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign rdata = mem[pipe[LAT-1]];

  typedef struct {
    bit          probe;
    int          xv;
    int          yv;
    bit          exp_ready;
    bit          exp_pix;
    int          exp_lat;
    logic [15:0] exp_addr;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   issued = 0;
  int   retired = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   mcnt = 0;

  // Monitor: a probe is compared at the first negedge; a transaction is
  // compared when ready rises, with the elapsed cycle count as latency.
  always @(negedge clk) begin
    if (issued > retired) begin
      cur = q[0];
      if (cur.probe) begin
        vectors++;
        if (ready !== cur.exp_ready || rdaddress !== cur.exp_addr) begin
          miscompares++;
          $display("FAIL probe(%0d,%0d): ready=%0b rdaddress=%0d, required ready=%0b rdaddress=%0d",
                   cur.xv, cur.yv, ready, rdaddress, cur.exp_ready, cur.exp_addr);
        end
        void'(q.pop_front());
        retired++;
        mcnt = 0;
      end else if (ready === 1'b1) begin
        vectors++;
        if (pixel !== cur.exp_pix || mcnt != cur.exp_lat || rdaddress !== cur.exp_addr) begin
          miscompares++;
          $display("FAIL tx(%0d,%0d): latency=%0d pixel=%0b rdaddress=%0d, required latency=%0d pixel=%0b rdaddress=%0d",
                   cur.xv, cur.yv, mcnt, pixel, rdaddress, cur.exp_lat, cur.exp_pix, cur.exp_addr);
        end
        void'(q.pop_front());
        retired++;
        mcnt = 0;
      end else if (mcnt >= BUDGET) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout(%0d,%0d): ready still 0 after %0d cycles, required ready after %0d",
                 cur.xv, cur.yv, mcnt, cur.exp_lat);
        void'(q.pop_front());
        retired++;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
  end

  function automatic bit pix_of(input int a, input int bi);
    logic [7:0] b;
    b = mem[a];
    return b[bi];
  endfunction

  // Called just after a rising edge; holds x,y until the monitor retires it.
  task automatic tx(input int xv, input int yv, input int flush_at,
                    input bit ep, input int el, input logic [15:0] ea);
    exp_t e;
    e.probe = 1'b0; e.xv = xv; e.yv = yv; e.exp_ready = 1'b1;
    e.exp_pix = ep; e.exp_lat = el; e.exp_addr = ea;
    x = xv[9:0];
    y = yv[9:0];
    q.push_back(e);
    issued++;
    for (int c = 0; c < BUDGET + 5; c++) begin
      flush = (c == flush_at);
      @(posedge clk);
      #1;
      if (retired == issued) break;
    end
    flush = 1'b0;
  endtask

  task automatic probe(input int xv, input int yv, input bit er, input logic [15:0] ea);
    exp_t e;
    e.probe = 1'b1; e.xv = xv; e.yv = yv; e.exp_ready = er;
    e.exp_pix = 1'b0; e.exp_lat = 0; e.exp_addr = ea;
    x = xv[9:0];
    y = yv[9:0];
    q.push_back(e);
    issued++;
    @(posedge clk);
    #1;
  endtask

  // Reference state: which byte address the cache holds, last fetched address.
  bit          m_valid;
  int          m_addr;
  logic [15:0] m_rd;
  int          px, py, r, xv, yv, a, fl, el;
  bit          inf, miss, ep;

  initial begin
    for (int i = 0; i < 38400; i++) mem[i] = 8'($urandom);
    mem[160] = 8'h80;
    mem[161] = 8'h01;
    mem[240] = 8'h08;
    mem[321] = 8'h02;
    mem[401] = 8'h00;
    for (int i = 0; i < int'(LAT); i++) pipe[i] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // First cycle after reset: in-frame request misses, rdaddress is 0.
    probe(7, 2, 1'b0, 16'd0);
    tx(7, 2, -1, 1'b1, LAT + 1, 16'd160);

`ifdef PIXEL_FETCH_PREFETCH_EN
    // Prefetch of 161 was issued on the hit cycle above.
    tx(8, 2, -1, 1'b1, LAT + 1, 16'd161);
    tx(7, 2, -1, 1'b1, 0, 16'd161);
    tx(8, 2, -1, 1'b1, 0, 16'd161);
`else
    tx(6, 2, -1, 1'b0, 0, 16'd160);
    tx(9, 4, -1, 1'b1, LAT + 2, 16'd321);
    tx(9, 5, -1, 1'b0, LAT + 2, 16'd401);
    tx(640, 0, -1, 1'b0, 0, 16'd401);
    tx(0, 480, -1, 1'b0, 0, 16'd401);
    // Flush in the FILL cycle: the held request has to fetch again.
    tx(3, 3, LAT + 1, 1'b1, 2 * (LAT + 2), 16'd240);
    tx(3, 3, -1, 1'b1, 0, 16'd240);

    // Reset while the fetch of 800 waits; next cycle must look freshly reset.
    x = 10'd0;
    y = 10'd10;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    probe(0, 10, 1'b0, 16'd0);
    tx(0, 10, -1, pix_of(800, 0), LAT + 1, 16'd800);

    m_valid = 1'b1;
    m_addr  = 800;
    m_rd    = 16'd800;
    px = 0;
    py = 10;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        xv = (px & ~7) | int'($urandom_range(0, 7));
        yv = py;
      end else if (r == 4) begin
        xv = int'($urandom_range(640, 1023));
        yv = int'($urandom_range(0, 1023));
      end else if (r == 5) begin
        xv = int'($urandom_range(0, 1023));
        yv = int'($urandom_range(480, 1023));
      end else begin
        xv = int'($urandom_range(0, 639));
        yv = int'($urandom_range(0, 479));
      end
      fl  = ($urandom_range(0, 7) == 0) ? 0 : -1;
      inf = (xv < 640) && (yv < 480);
      a   = yv * 80 + xv / 8;
      miss = inf && !(m_valid && m_addr == a);
      if (!inf) begin
        ep = 1'b0;
        el = 0;
      end else begin
        ep = pix_of(a, xv % 8);
        el = miss ? int'(LAT) + 2 : 0;
      end
      if (miss) m_rd = 16'(a);
      tx(xv, yv, fl, ep, el, m_rd);
      if (miss) begin
        m_valid = 1'b1;
        m_addr  = a;
      end else if (fl == 0) begin
        m_valid = 1'b0;
      end
      if (inf) begin
        px = xv;
        py = yv;
      end
    end
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
